// File: rtl/mult_sched_if.sv
// Request/response bus between the requesters and the multiplier scheduler.
// Operands are packed 64 bits per requester, lowest requester in the low bits.
interface mult_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_signed;
    logic [64*NREQ-1:0]   req_a;
    logic [64*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      res_valid;
    logic [127:0]         res_o;

    modport master (
        output req_valid, req_signed, req_a, req_b,
        input  req_ready, res_valid, res_o
    );

    modport slave (
        input  req_valid, req_signed, req_a, req_b,
        output req_ready, res_valid, res_o
    );
endinterface

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one pipelined 64x64 unsigned multiplier.
// Signed operands go in as magnitudes; the product is negated on the way out.
module mult_sched #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mult_sched_if.slave   rq,
    output logic          mul_ce,
    output logic [63:0]   mul_a,
    output logic [63:0]   mul_b,
    input  logic [127:0]  mul_o,
    output logic          idle
);
    localparam int IW = $clog2(NREQ);

    typedef struct packed {
        logic          v;
        logic [IW-1:0] id;
        logic          neg;
    } tag_t;

    logic [IW-1:0]   r_rr;
    logic [63:0]     r_mul_a;
    logic [63:0]     r_mul_b;
    tag_t            r_itag;
    tag_t            r_tag [MUL_LAT];
    logic [NREQ-1:0] r_rv;
    logic [127:0]    r_res;

    logic            w_hs;
    logic [IW-1:0]   w_gid;
    logic [IW-1:0]   w_idx;
    logic [NREQ-1:0] w_gnt;
    logic            w_s;
    logic [63:0]     w_a;
    logic [63:0]     w_b;
    logic [63:0]     w_ma;
    logic [63:0]     w_mb;
    logic            w_neg;
    logic [127:0]    w_res;
    logic            w_busy;
    tag_t            w_last;

    // First valid requester at or after rr+1, wrapping modulo NREQ
    always_comb begin
        w_hs  = 1'b0;
        w_gid = r_rr;
        w_idx = '0;
        w_gnt = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IW'((int'(r_rr) + k) % NREQ);
            if (!w_hs && rq.req_valid[w_idx]) begin
                w_hs  = 1'b1;
                w_gid = w_idx;
            end
        end
        w_hs = w_hs & rst_n;
        if (w_hs)
            w_gnt[w_gid] = 1'b1;
    end

    assign rq.req_ready = w_gnt;

    always_comb begin
        w_s   = rq.req_signed[w_gid];
        w_a   = rq.req_a[64*w_gid +: 64];
        w_b   = rq.req_b[64*w_gid +: 64];
        w_ma  = (w_s & w_a[63]) ? (~w_a + 64'd1) : w_a;
        w_mb  = (w_s & w_b[63]) ? (~w_b + 64'd1) : w_b;
        w_neg = w_s & (w_a[63] ^ w_b[63]);
    end

    assign w_last = r_tag[MUL_LAT-1];
    assign w_res  = w_last.neg ? (~mul_o + 128'd1) : mul_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr    <= IW'(NREQ-1);
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_itag  <= '0;
            for (int i = 0; i < MUL_LAT; i++)
                r_tag[i] <= '0;
            r_rv    <= '0;
            r_res   <= '0;
        end else begin
            if (w_hs) begin
                r_rr    <= w_gid;
                r_mul_a <= w_ma;
                r_mul_b <= w_mb;
                r_itag  <= '{v: 1'b1, id: w_gid, neg: w_neg};
            end else begin
                r_itag  <= '0;
            end
            // Tags trail the operands so the last stage lines up with mul_o
            r_tag[0] <= r_itag;
            for (int i = 1; i < MUL_LAT; i++)
                r_tag[i] <= r_tag[i-1];
            if (w_last.v) begin
                r_res <= w_res;
                r_rv  <= {{(NREQ-1){1'b0}}, 1'b1} << w_last.id;
            end else begin
                r_rv  <= '0;
            end
        end
    end

    always_comb begin
        w_busy = r_itag.v | (|r_rv);
        for (int i = 0; i < MUL_LAT; i++)
            w_busy = w_busy | r_tag[i].v;
    end

    assign idle         = ~w_busy;
    assign mul_ce       = rst_n;
    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;
    assign rq.res_valid = r_rv;
    assign rq.res_o     = r_res;
endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: behavioural multiplier, arithmetic reference model,
// directed vector table and randomized traffic.
module tb_mult_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mul_ce;
    logic [63:0] mul_a, mul_b;
    logic [127:0] mul_o;
    logic idle;

    mult_sched_if #(.NREQ(NREQ)) bus ();

    mult_sched #(.NREQ(NREQ), .MUL_LAT(LAT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rq     (bus),
        .mul_ce (mul_ce),
        .mul_a  (mul_a),
        .mul_b  (mul_b),
        .mul_o  (mul_o),
        .idle   (idle)
    );

    always #5 clk = ~clk;

    // Free-running multiplier with LAT register stages
    logic [127:0] p [LAT];
    always @(posedge clk) begin
        if (mul_ce) begin
            p[0] <= {64'd0, mul_a} * {64'd0, mul_b};
            for (int i = 1; i < LAT; i++)
                p[i] <= p[i-1];
        end
    end
    assign mul_o = p[LAT-1];

    typedef struct {
        logic        s;
        logic [63:0] a;
        logic [63:0] b;
    } op_t;

    typedef struct {
        int           due;
        int           id;
        logic [127:0] p;
    } exp_t;

    typedef struct {
        int           id;
        logic         s;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp;
    } vec_t;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int m_rr = NREQ - 1;
    int mj;
    int gid;
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] erv;
    op_t  dq [NREQ][$];
    exp_t q [$];
    int   glog [$];
    int   gcyc [$];
    vec_t tbl [6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] ref_mul(input logic s,
                                             input logic [63:0] a,
                                             input logic [63:0] b);
        logic signed [127:0] sa, sb;
        if (s) begin
            sa = {{64{a[63]}}, a};
            sb = {{64{b[63]}}, b};
            return sa * sb;
        end
        return {64'd0, a} * {64'd0, b};
    endfunction

    // Reference model: round-robin grant and in-order results 5 clocks on
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_rr = NREQ - 1;
            chk("rst_ready", bus.req_ready, 0);
            chk("rst_res_valid", bus.res_valid, 0);
            chk("rst_res_o", bus.res_o, 0);
            chk("rst_mul_a", mul_a, 0);
            chk("rst_mul_b", mul_b, 0);
            chk("rst_mul_ce", mul_ce, 0);
            chk("rst_idle", idle, 1);
        end else begin
            gid = -1;
            eg = '0;
            for (int k = 1; k <= NREQ; k++) begin
                mj = (m_rr + k) % NREQ;
                if (gid < 0 && bus.req_valid[mj])
                    gid = mj;
            end
            if (gid >= 0)
                eg[gid] = 1'b1;
            chk("grant", bus.req_ready, eg);
            chk("mul_ce", mul_ce, 1);
            chk("idle", idle, q.size() == 0);
            erv = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                erv[q[0].id] = 1'b1;
                chk("res_o", bus.res_o, q[0].p);
                void'(q.pop_front());
            end
            chk("res_valid", bus.res_valid, erv);
            if (gid >= 0) begin
                q.push_back('{cyc + 6, gid,
                    ref_mul(bus.req_signed[gid],
                            bus.req_a[64*gid +: 64],
                            bus.req_b[64*gid +: 64])});
                m_rr = gid;
                glog.push_back(gid);
                gcyc.push_back(cyc + 1);
            end
        end
    end

    // Requester driver: hold each op until its handshake, then load the next
    initial begin
        logic [NREQ-1:0] hs;
        op_t o;
        bus.req_valid  = '0;
        bus.req_signed = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        forever begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i] || !bus.req_valid[i]) begin
                    if (dq[i].size() > 0) begin
                        o = dq[i].pop_front();
                        bus.req_valid[i]        = 1'b1;
                        bus.req_signed[i]       = o.s;
                        bus.req_a[64*i +: 64]   = o.a;
                        bus.req_b[64*i +: 64]   = o.b;
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
        end
    end

    function automatic bit quiet();
        for (int i = 0; i < NREQ; i++)
            if (dq[i].size() > 0)
                return 1'b0;
        return (bus.req_valid == 0) && (q.size() == 0) && idle;
    endfunction

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (t < 300 && !quiet()) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_drain_timeout"}, t >= 300, 0);
        @(negedge clk);
    endtask

    task automatic single(input string nm, input int id, input logic s,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [127:0] exp);
        int hs_c;
        int t;
        bit got;
        logic [NREQ-1:0] rv;
        dq[id].push_back('{s, a, b});
        got = 1'b0;
        hs_c = 0;
        for (t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus.req_valid[id] && bus.req_ready[id]) begin
                got = 1'b1;
                hs_c = cyc + 1;
            end
        end
        chk({nm, "_handshake"}, got, 1);
        if (got) begin
            got = 1'b0;
            for (t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                if (|bus.res_valid)
                    got = 1'b1;
            end
            chk({nm, "_result_seen"}, got, 1);
            rv = '0;
            rv[id] = 1'b1;
            chk({nm, "_latency"}, cyc - hs_c, 5);
            chk({nm, "_res_valid"}, bus.res_valid, rv);
            chk({nm, "_res_o"}, bus.res_o, exp);
            @(negedge clk);
            chk({nm, "_idle_after"}, idle, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int pulses;
        bit got;
        tbl[0] = '{0, 1'b0, 64'd10, 64'd10, 128'd100};
        tbl[1] = '{1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 64'd1700000,
                   ~128'd35700000 + 128'd1};
        tbl[2] = '{2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                   128'h1_FFFF_FFFF_FFFF_FFFE};
        tbl[3] = '{0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ~128'd0};
        tbl[4] = '{1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9,
                   64'hFFFF_FFFF_FFFF_FFFA, 128'd42};
        tbl[5] = '{3, 1'b1, 64'h8000_0000_0000_0000,
                   64'h8000_0000_0000_0000, 128'd1 << 126};

        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            single($sformatf("vec%0d", i), tbl[i].id, tbl[i].s,
                   tbl[i].a, tbl[i].b, tbl[i].exp);

        // Contention: pointer sits at 3, so grants run 0,1,2,3
        glog.delete();
        gcyc.delete();
        dq[0].push_back('{1'b0, 64'd21, 64'd1700000});
        dq[1].push_back('{1'b0, 64'd215000, 64'd11});
        dq[2].push_back('{1'b0, 64'd3, 64'd3});
        dq[3].push_back('{1'b0, 64'd7, 64'd6});
        drain("contend");
        chk("contend_count", glog.size(), 4);
        if (glog.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("contend_gnt%0d", k), glog[k], k);
                chk($sformatf("contend_cyc%0d", k), gcyc[k] - gcyc[0], k);
            end
        end

        glog.delete();
        for (int k = 0; k < 5; k++) begin
            dq[0].push_back('{1'b0, 64'(k + 1), 64'd3});
            dq[2].push_back('{1'b1, 64'(-(k + 2)), 64'd5});
        end
        drain("fair");
        chk("fair_count", glog.size(), 10);
        if (glog.size() == 10)
            for (int k = 0; k < 10; k++)
                chk($sformatf("fair_gnt%0d", k), glog[k], (k % 2) * 2);

        // Reset two cycles after the first of three back-to-back issues
        for (int k = 0; k < 3; k++)
            dq[0].push_back('{1'b0, 64'(100 + k), 64'd7});
        got = 1'b0;
        for (t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = bus.req_valid[0] & bus.req_ready[0];
        end
        chk("midrst_handshake", got, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        dq[1].push_back('{1'b0, 64'd9, 64'd9});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.res_valid != 0 && bus.res_valid != 4'b0010)
                pulses++;
        end
        chk("midrst_stale_results", pulses, 0);
        chk("midrst_idle", idle, 1);
        drain("midrst");
        single("post_rst", 2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4,
               ~128'd12 + 128'd1);

        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if ($urandom_range(2) == 0) begin
                int i;
                op_t o;
                i = $urandom_range(NREQ - 1);
                o.s = 1'($urandom);
                case ($urandom_range(3))
                    0: o.a = {$urandom, $urandom};
                    1: o.a = 64'($urandom_range(1000));
                    2: o.a = 64'h8000_0000_0000_0000;
                    default: o.a = 64'hFFFF_FFFF_FFFF_FFFF;
                endcase
                o.b = ($urandom_range(1) == 0) ? {$urandom, $urandom}
                                               : 64'($urandom_range(50));
                if (dq[i].size() < 3)
                    dq[i].push_back(o);
            end
        end
        drain("random");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/mult_sched.md
# mult_sched

Scheduler and sign-handling front end that shares one pipelined `mult64x64` instance among `NREQ` requesters. It runs round-robin arbitration over valid/ready request ports and issues at most one operation per cycle into the multiplier. For signed operations it converts operands to magnitudes on the way in and negates the product on the way out. It carries each operation's requester ID down a tag pipeline matched to the multiplier latency, and returns results on a shared, ID-steered result bus.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; 2..8.
- `MUL_LAT`, 4: clocks from `mul_a`/`mul_b` presented to `mul_o` valid; must equal the instanced multiplier's latency.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: request present, one bit per requester.
- `req_ready` out NREQ: one-hot grant; a handshake occurs when `req_valid[i] & req_ready[i]`.
- `req_signed` in NREQ: 1 means the operands are two's-complement.
- `req_a` in NREQ*64: operand A; requester i uses `[64*i+63:64*i]`.
- `req_b` in NREQ*64: operand B; same packing as `req_a`.
- `res_valid` out NREQ: one-hot result strobe, one cycle, no backpressure.
- `res_o` out 128: product for the requester flagged in `res_valid`.
- `mul_ce` out 1: multiplier clock enable.
- `mul_a` out 64: multiplier operand A, registered.
- `mul_b` out 64: multiplier operand B, registered.
- `mul_o` in 128: unsigned product from the multiplier.
- `idle` out 1: no operation in flight.

## Operation
- **Arbitration.**
  - A round-robin pointer `rr` resets to `NREQ-1`.
  - The grant goes to the first `req_valid` bit at or after `rr+1`, searching modulo `NREQ`.
  - `req_ready` is a combinational function of `req_valid` and `rr`.
  - At most one bit of `req_ready` is set, and only when the matching `req_valid` is set.
  - `rr` updates to the granted index on a handshake; otherwise it holds.
- **Issue stage.** On a handshake, the following are registered:
  - `mul_a = (s & a[63]) ? -a : a` and `mul_b = (s & b[63]) ? -b : b`, as unsigned 64-bit values. `-(2^63)` yields `0x8000_0000_0000_0000`, which is correct as a magnitude.
  - `neg = s & (a[63] ^ b[63])`.
  - Tag `{valid=1, id, neg}` enters the tag shift register.
  - With no handshake, a tag with valid=0 enters; `mul_a`/`mul_b` hold.
- **Tag pipeline.** `MUL_LAT` stages, shifting every clock. The multiplier runs free; there are no stalls.
- **Output stage.** Registered when the last tag stage is valid:
  - `res_o = neg ? (~mul_o + 1) : mul_o`, computed over 128 bits.
  - `res_valid = 1 << id`.
  - Otherwise `res_valid = 0` and `res_o` holds.
- **Other outputs.**
  - `mul_ce` is 1 whenever out of reset.
  - `idle` = no valid bit in the tag stages and `res_valid == 0`.

## Timing
- **Reset values.**
  - `req_ready` = 0 (all `req_valid` are ignored while `rst_n` is low).
  - `res_valid` = 0, `res_o` = 0, `mul_a` = 0, `mul_b` = 0, `mul_ce` = 0, `idle` = 1.
  - All tag valid bits = 0; `rr = NREQ-1`.
- **Latency.**
  - Handshake at edge E: operands on `mul_a`/`mul_b` after E, `mul_o` valid after E+`MUL_LAT`.
  - `res_valid` is high for exactly the cycle after edge E+`MUL_LAT`+1.
  - Default: 5 clocks from handshake edge to result edge.
- **Throughput.** One handshake per cycle. Results return in issue order, one per cycle, with no gaps beyond the issue gaps.
- **Simultaneous requests.**
  - Exactly one is granted per cycle.
  - Losers keep `req_valid` high with stable operands until granted.
  - A requester may drop `req_valid` before it is granted without effect.
- **Back-to-back from one requester.** Allowed. Each accepted operation produces its own `res_valid` pulse.
- **Reset mid-flight.**
  - Assertion immediately clears all tags and outputs.
  - No `res_valid` is produced for operations accepted before reset, even after deassertion.
  - Stale `mul_o` values are ignored.
- **Pointer wrap.** The `rr` search wraps from `NREQ-1` to 0.

## Test plan
- **Single unsigned.** Requester 0: a=10, b=10, unsigned. Expect `req_ready[0]` in the same cycle, `res_valid=4'b0001`, and `res_o=100` exactly 5 clocks later. `idle` returns to 1 the next cycle.
- **Full contention.** All 4 valid in one cycle with (21,1700000), (215000,11), (3,3), (7,6). Expect grants 0,1,2,3 on consecutive cycles. Expect results 35700000, 2365000, 9, 42 on four consecutive cycles, with `res_valid` 0001, 0010, 0100, 1000.
- **Signed/unsigned mix.**
  - Requester 1 signed, a=-21, b=1700000: `res_o`=128-bit two's complement of 35700000.
  - Requester 2 unsigned, a=`0xFFFF_FFFF_FFFF_FFFF`, b=2: `res_o=0x1_FFFF_FFFF_FFFF_FFFE`.
- **Signed extremes.**
  - a=b=`0x8000_0000_0000_0000`, signed: `res_o=2^126`.
  - a=-1, b=1, signed: `res_o` all ones.
- **Fairness.** Requesters 0 and 2 hold `req_valid` continuously for 10 cycles. Grants strictly alternate 0,2,0,2,…, and requesters 1 and 3 are never granted.
- **Reset mid-flight.** Issue 3 ops, then pulse `rst_n` low 2 cycles after the first handshake. Expect no `res_valid` afterwards, `idle=1`, and a following op returns a correct result with the 5-clock latency.
